dff_pipe_chain: RTL and testbench

- Parametrised successor of the single D flip-flop: a WIDTH-bit, DEPTH-stage register chain with per-stage valid bits and valid/ready flow control.
- Bubbles collapse under backpressure, so the chain also acts as a small elastic buffer.
- Supports a synchronous flush and exposes an occupancy count.
- Used as the standard retiming/delay element between datapath blocks.

---
 rtl/dff_pkg.sv | 12 +
 rtl/dff_pipe_stage.sv | 40 ++++
 rtl/dff_pipe_chain.sv | 93 +++++++++
 tb/tb_dff_pipe_chain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the register-chain family of blocks.
package dff_pkg;

  localparam int DFF_WIDTH_DEF = 8;
  localparam int DFF_DEPTH_DEF = 4;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One stage of the register chain: a data register plus its valid bit.
// The data register only updates when a valid word is loaded, so an
// empty stage keeps its stale contents instead of toggling.
module dff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             load_en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid bit follows the source whenever the stage is allowed to move.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load_en) begin
      valid <= src_valid;
    end
  end

  // Data register captures only real words; bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= RESET_VAL;
    end else if (flush) begin
      data <= RESET_VAL;
    end else if (load_en && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/dff_pipe_chain.sv
// WIDTH-bit, DEPTH-stage register chain with valid/ready flow control.
// Bubbles collapse under backpressure, so the chain doubles as a small
// elastic buffer. Stage 0 is the input end; the last stage drives out_*.
module dff_pipe_chain
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH_DEF,
  parameter int               DEPTH     = DFF_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] count_q;

  // A stage may move when it, or any stage downstream of it, is empty, or
  // when the output is draining. Walked with a scalar accumulator so the
  // ready vector never feeds back on itself.
  always_comb begin
    logic r;
    r     = out_ready;
    ready = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r        = r || !valid[i];
      ready[i] = r;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (g == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = valid[g-1];
      assign src_data  = data_q[g-1];
    end

    dff_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .load_en  (ready[g]),
      .src_valid(src_valid),
      .src_data (src_data),
      .valid    (valid[g]),
      .data     (data_q[g])
    );
  end

  // During a flush cycle both handshakes are blocked so nothing is
  // accepted or delivered while the stages are being cleared.
  assign in_ready  = ready[0] && !flush;
  assign out_valid = valid[DEPTH-1] && !flush;
  assign out_data  = data_q[DEPTH-1];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign count     = count_q;

  // Occupancy tracks handshakes; simultaneous in/out leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (in_fire && !out_fire) begin
      count_q <= count_q + CNT_W'(1);
    end else if (!in_fire && out_fire) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Bench for dff_pipe_chain (WIDTH=8, DEPTH=3, RESET_VAL=0): a directed
// vector table followed by a randomized run against a queue model.
module tb_dff_pipe_chain;

  localparam int DEPTH = 3;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;

  dff_pipe_chain #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       orr;
    logic       chk;
    logic       e_ir;
    logic       e_ov;
    logic [1:0] e_cnt;
    logic       chk_d;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [7:0] d;
    int         pos;
  } ent_t;

  ent_t q[$];

  task automatic add(input logic rn, input logic fl, input logic iv, input logic [7:0] id,
                     input logic orr, input logic chk, input logic e_ir, input logic e_ov,
                     input logic [1:0] e_cnt, input logic chk_d, input logic [7:0] e_d);
    vec_t v;
    v.rn = rn; v.fl = fl; v.iv = iv; v.id = id; v.orr = orr; v.chk = chk;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.chk_d = chk_d; v.e_d = e_d;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    bit exp_ir, exp_ov, fire_in, fire_out;
    int cap, np;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    //   rn fl iv id     or  chk ir ov cnt chkd d
    // reset held for two edges with a word offered
    add(0, 0, 1, 8'hAA, 0,  0,  0, 0, 0,  0, 8'h00);
    add(0, 0, 1, 8'hAA, 0,  1,  1, 0, 0,  1, 8'h00);
    // streaming, out_ready high
    add(1, 0, 1, 8'h01, 1,  1,  1, 0, 0,  1, 8'h00);
    add(1, 0, 1, 8'h02, 1,  1,  1, 0, 1,  0, 8'h00);
    add(1, 0, 1, 8'h03, 1,  1,  1, 0, 2,  0, 8'h00);
    add(1, 0, 1, 8'h04, 1,  1,  1, 1, 3,  1, 8'h01);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 3,  1, 8'h02);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 2,  1, 8'h03);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 1,  1, 8'h04);
    // backpressure
    add(1, 0, 1, 8'h10, 0,  1,  1, 0, 0,  0, 8'h00);
    add(1, 0, 1, 8'h11, 0,  1,  1, 0, 1,  0, 8'h00);
    add(1, 0, 1, 8'h12, 0,  1,  1, 0, 2,  0, 8'h00);
    add(1, 0, 1, 8'h13, 0,  1,  0, 1, 3,  1, 8'h10);
    add(1, 0, 1, 8'h13, 1,  1,  1, 1, 3,  1, 8'h10);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 3,  1, 8'h11);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 2,  1, 8'h12);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 1,  1, 8'h13);
    // bubble collapse
    add(1, 0, 1, 8'h20, 0,  1,  1, 0, 0,  0, 8'h00);
    add(1, 0, 0, 8'h00, 0,  1,  1, 0, 1,  0, 8'h00);
    add(1, 0, 0, 8'h00, 0,  1,  1, 0, 1,  0, 8'h00);
    add(1, 0, 1, 8'h21, 0,  1,  1, 1, 1,  1, 8'h20);
    add(1, 0, 0, 8'h00, 0,  1,  1, 1, 2,  1, 8'h20);
    add(1, 0, 0, 8'h00, 0,  1,  1, 1, 2,  1, 8'h20);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 2,  1, 8'h20);
    add(1, 0, 0, 8'h00, 1,  1,  1, 1, 1,  1, 8'h21);
    // flush with three words stored and a word offered
    add(1, 0, 1, 8'h30, 0,  1,  1, 0, 0,  0, 8'h00);
    add(1, 0, 1, 8'h31, 0,  1,  1, 0, 1,  0, 8'h00);
    add(1, 0, 1, 8'h32, 0,  1,  1, 0, 2,  0, 8'h00);
    add(1, 1, 1, 8'h33, 1,  1,  0, 0, 3,  0, 8'h00);
    add(1, 0, 0, 8'h00, 1,  1,  1, 0, 0,  1, 8'h00);
    add(1, 0, 0, 8'h00, 1,  1,  1, 0, 0,  1, 8'h00);
    // reset mid-stream while a word is being accepted
    add(1, 0, 1, 8'h40, 0,  1,  1, 0, 0,  1, 8'h00);
    add(1, 0, 1, 8'h41, 0,  1,  1, 0, 1,  0, 8'h00);
    add(0, 0, 1, 8'h42, 0,  1,  1, 0, 2,  0, 8'h00);
    add(1, 0, 0, 8'h00, 1,  1,  1, 0, 0,  1, 8'h00);
    add(1, 0, 0, 8'h00, 1,  1,  1, 0, 0,  1, 8'h00);
    add(1, 0, 0, 8'h00, 1,  1,  1, 0, 0,  1, 8'h00);

    foreach (vecs[i]) begin
      reset_n   = vecs[i].rn;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].orr;
      #1;
      if (vecs[i].chk) begin
        cmp($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
        cmp($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
        cmp($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      end
      if (vecs[i].chk_d) begin
        cmp($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].e_d));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized run. Model: an ordered list of words with positions; each
    // cycle every word steps one position toward the output unless the word
    // directly ahead of it stayed put.
    q.delete();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      exp_ir = !flush && ((q.size() < DEPTH) || out_ready);
      exp_ov = !flush && (q.size() > 0) && (q[0].pos == DEPTH - 1);
      cmp($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(exp_ir));
      cmp($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(exp_ov));
      cmp($sformatf("rnd%0d count", cyc), 32'(count), 32'(q.size()));
      if (exp_ov) cmp($sformatf("rnd%0d out_data", cyc), 32'(out_data), 32'(q[0].d));

      if (flush) begin
        q.delete();
      end else begin
        fire_out = exp_ov && out_ready;
        fire_in  = in_valid && exp_ir;
        if (fire_out) void'(q.pop_front());
        cap = DEPTH - 1;
        foreach (q[k]) begin
          np = q[k].pos + 1;
          if (np > cap) np = cap;
          q[k].pos = np;
          cap = np - 1;
        end
        if (fire_in) q.push_back('{d: in_data, pos: 0});
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
